// File: rtl/seg_readback_decoder_if.sv
// Segment readback bus: a strobed, digit-qualified segment pattern going in,
// and the decoded value, status pulses and error tally coming back out.
// The master drives the segment side; the decoder is the slave.
interface seg_readback_decoder_if #(
  parameter int ERR_W = 8
) ();

  logic [7:0]       seg_in;
  logic             seg_sel;
  logic             seg_stb;
  logic [6:0]       value;
  logic             value_valid;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output seg_in, seg_sel, seg_stb,
    input  value, value_valid, err, err_count
  );

  modport slave (
    input  seg_in, seg_sel, seg_stb,
    output value, value_valid, err, err_count
  );

endinterface

// File: rtl/seg_readback_decoder.sv
// Two-digit seven-segment readback decoder. It pairs a tens frame with the
// following ones frame, decodes both back to a 0-99 value, and publishes the
// value once STABLE consecutive identical legal pairs have been seen.
// Illegal patterns and a ones frame without a preceding tens frame raise err.
// Optional feature macro: SEG_DP_CHECK_EN (a lit decimal point makes the
// pattern illegal; when undefined the decimal point is masked off).
module seg_readback_decoder #(
  parameter int STABLE = 3,
  parameter int ERR_W  = 8
) (
  input  logic                   hz100,
  input  logic                   reset,
  seg_readback_decoder_if.slave  bus
);

  typedef enum logic {
    WAIT_TENS,
    WAIT_ONES
  } state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  state_t           state;
  logic [7:0]       tens_pat;
  logic [3:0]       match_cnt;
  logic             cand_valid;
  logic [6:0]       held_cand;
  logic [6:0]       value_q;
  logic             value_valid_q;
  logic             err_q;
  logic [ERR_W-1:0] err_count_q;

  logic [4:0]       tens_dec;
  logic [4:0]       ones_dec;
  logic             pair_legal;
  logic [6:0]       candidate;
  logic             is_pair;
  logic             seq_err;
  logic             err_event;

  // Map a segment pattern to {legal, digit}; anything the encoder cannot emit is illegal.
  function automatic logic [4:0] decode(input logic [7:0] pat);
    logic [7:0] p;
    p = pat;
`ifndef SEG_DP_CHECK_EN
    p[7] = 1'b0;
`endif
    case (p)
      8'h3F:   decode = {1'b1, 4'd0};
      8'h06:   decode = {1'b1, 4'd1};
      8'h5B:   decode = {1'b1, 4'd2};
      8'h4F:   decode = {1'b1, 4'd3};
      8'h66:   decode = {1'b1, 4'd4};
      8'h6D:   decode = {1'b1, 4'd5};
      8'h7D:   decode = {1'b1, 4'd6};
      8'h07:   decode = {1'b1, 4'd7};
      8'h7F:   decode = {1'b1, 4'd8};
      8'h6F:   decode = {1'b1, 4'd9};
      default: decode = 5'd0;
    endcase
  endfunction

  // Decode the latched tens and incoming ones frame, and classify this strobe.
  always_comb begin
    tens_dec   = decode(tens_pat);
    ones_dec   = decode(bus.seg_in);
    pair_legal = tens_dec[4] & ones_dec[4];
    candidate  = ({3'b000, tens_dec[3:0]} * 7'd10) + {3'b000, ones_dec[3:0]};
    is_pair    = bus.seg_stb && (state == WAIT_ONES) && !bus.seg_sel;
    seq_err    = bus.seg_stb && (state == WAIT_TENS) && !bus.seg_sel;
    err_event  = seq_err || (is_pair && !pair_legal);
  end

  // Frame sequencing FSM with stability tracking and registered publish.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state         <= WAIT_TENS;
      tens_pat      <= 8'h00;
      match_cnt     <= 4'd0;
      cand_valid    <= 1'b0;
      held_cand     <= 7'd0;
      value_q       <= 7'd0;
      value_valid_q <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      if (bus.seg_stb) begin
        case (state)
          WAIT_TENS: begin
            if (bus.seg_sel) begin
              tens_pat <= bus.seg_in;
              state    <= WAIT_ONES;
            end
          end
          WAIT_ONES: begin
            if (bus.seg_sel) begin
              tens_pat <= bus.seg_in;
            end else begin
              state <= WAIT_TENS;
              if (!pair_legal) begin
                match_cnt  <= 4'd0;
                cand_valid <= 1'b0;
              end else if (cand_valid && (candidate == held_cand)) begin
                if (match_cnt < STABLE_C) begin
                  match_cnt <= match_cnt + 4'd1;
                  if ((match_cnt + 4'd1) == STABLE_C) begin
                    value_q       <= candidate;
                    value_valid_q <= 1'b1;
                  end
                end
              end else begin
                held_cand  <= candidate;
                cand_valid <= 1'b1;
                match_cnt  <= 4'd1;
                if (STABLE_C == 4'd1) begin
                  value_q       <= candidate;
                  value_valid_q <= 1'b1;
                end
              end
            end
          end
          default: state <= WAIT_TENS;
        endcase
      end
    end
  end

  // Error pulse and its saturating tally move together so the count is current while err is high.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q <= err_event;
      if (err_event && (err_count_q != {ERR_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.err         = err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Directed bench for seg_readback_decoder: one STABLE=3/ERR_W=8 instance for
// the main behaviour and one STABLE=1/ERR_W=2 instance for immediate publish
// and error-counter saturation. Honours SEG_DP_CHECK_EN when defined.
module tb_seg_readback_decoder;

  logic hz100;
  logic reset;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] got_value;
  logic [31:0] got_vv;
  logic [31:0] got_err;
  logic [31:0] got_cnt;

  seg_readback_decoder_if #(.ERR_W(8)) bus1 ();
  seg_readback_decoder_if #(.ERR_W(2)) bus2 ();

  seg_readback_decoder #(.STABLE(3), .ERR_W(8)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus1.slave)
  );

  seg_readback_decoder #(.STABLE(1), .ERR_W(2)) dut2 (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge.
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic capture(input bit second);
    if (second) begin
      got_value = 32'(bus2.value);
      got_vv    = 32'(bus2.value_valid);
      got_err   = 32'(bus2.err);
      got_cnt   = 32'(bus2.err_count);
    end else begin
      got_value = 32'(bus1.value);
      got_vv    = 32'(bus1.value_valid);
      got_err   = 32'(bus1.err);
      got_cnt   = 32'(bus1.err_count);
    end
  endtask

  // One strobed frame; returns one cycle later with that frame's response captured.
  task automatic apply_stimulus(input bit second, input logic sel, input logic [7:0] pat);
    @(negedge hz100);
    if (second) begin
      bus2.seg_sel = sel; bus2.seg_in = pat; bus2.seg_stb = 1'b1;
    end else begin
      bus1.seg_sel = sel; bus1.seg_in = pat; bus1.seg_stb = 1'b1;
    end
    @(negedge hz100);
    bus1.seg_stb = 1'b0;
    bus2.seg_stb = 1'b0;
    capture(second);
  endtask

  task automatic apply_pair(input bit second, input logic [7:0] tens, input logic [7:0] ones);
    apply_stimulus(second, 1'b1, tens);
    apply_stimulus(second, 1'b0, ones);
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    bus1.seg_in = 8'h00; bus1.seg_sel = 1'b0; bus1.seg_stb = 1'b0;
    bus2.seg_in = 8'h00; bus2.seg_sel = 1'b0; bus2.seg_stb = 1'b0;
    repeat (3) @(negedge hz100);
    reset = 1'b0;
    @(negedge hz100);
    capture(1'b0);
    check_output("rst_value", got_value, 0);
    check_output("rst_vv",    got_vv,    0);
    check_output("rst_err",   got_err,   0);
    check_output("rst_cnt",   got_cnt,   0);

    // 37 three times publishes on the third, a fourth repeat stays quiet.
    apply_pair(1'b0, 8'h4F, 8'h07);
    check_output("p37_1_vv", got_vv, 0);
    apply_pair(1'b0, 8'h4F, 8'h07);
    check_output("p37_2_vv", got_vv, 0);
    apply_pair(1'b0, 8'h4F, 8'h07);
    check_output("p37_3_vv", got_vv, 1);
    check_output("p37_3_value", got_value, 37);
    check_output("p37_3_err", got_err, 0);
    apply_pair(1'b0, 8'h4F, 8'h07);
    check_output("p37_4_vv", got_vv, 0);

    // Blank tens (encoder output for 100) is illegal and clears the run.
    apply_pair(1'b0, 8'h00, 8'h3F);
    check_output("blank_err", got_err, 1);
    check_output("blank_cnt", got_cnt, 1);
    check_output("blank_vv",  got_vv,  0);

    // 37,37,42,42,42: only the fifth pair publishes.
    apply_pair(1'b0, 8'h4F, 8'h07);
    check_output("s37a_vv", got_vv, 0);
    apply_pair(1'b0, 8'h4F, 8'h07);
    check_output("s37b_vv", got_vv, 0);
    apply_pair(1'b0, 8'h66, 8'h5B);
    check_output("s42a_vv", got_vv, 0);
    apply_pair(1'b0, 8'h66, 8'h5B);
    check_output("s42b_vv", got_vv, 0);
    apply_pair(1'b0, 8'h66, 8'h5B);
    check_output("s42c_vv", got_vv, 1);
    check_output("s42c_value", got_value, 42);
    check_output("s42c_cnt", got_cnt, 1);

    // Three pairs of 10 after the error.
    for (int i = 0; i < 3; i++) apply_pair(1'b0, 8'h06, 8'h3F);
    check_output("p10_vv", got_vv, 1);
    check_output("p10_value", got_value, 10);

    // Ones frame with no tens frame pending is a sequencing error.
    apply_stimulus(1'b0, 1'b0, 8'h3F);
    check_output("seq_err", got_err, 1);
    check_output("seq_cnt", got_cnt, 2);

    // Second tens frame overwrites the first: pair evaluates as 49.
    apply_stimulus(1'b0, 1'b1, 8'h5B);
    apply_stimulus(1'b0, 1'b1, 8'h66);
    check_output("tens_ovr_err", got_err, 0);
    apply_stimulus(1'b0, 1'b0, 8'h6F);
    check_output("p49_1_err", got_err, 0);
    check_output("p49_1_vv", got_vv, 0);
    apply_pair(1'b0, 8'h66, 8'h6F);
    apply_pair(1'b0, 8'h66, 8'h6F);
    check_output("p49_3_vv", got_vv, 1);
    check_output("p49_3_value", got_value, 49);

    // Tens with decimal point lit.
    for (int i = 0; i < 3; i++) begin
      apply_pair(1'b0, 8'hBF, 8'h3F);
`ifdef SEG_DP_CHECK_EN
      check_output("dp_err", got_err, 1);
`else
      check_output("dp_err", got_err, 0);
`endif
    end
`ifdef SEG_DP_CHECK_EN
    check_output("dp_cnt", got_cnt, 5);
    check_output("dp_vv", got_vv, 0);
`else
    check_output("dp_vv", got_vv, 1);
    check_output("dp_value", got_value, 0);
    check_output("dp_cnt", got_cnt, 2);
`endif

    // Six back-to-back strobes forming three pairs of 56.
    for (int i = 0; i < 6; i++) begin
      @(negedge hz100);
      if (i == 5) begin
        capture(1'b0);
        check_output("b2b_early_vv", got_vv, 0);
      end
      bus1.seg_sel = (i % 2 == 0);
      bus1.seg_in  = (i % 2 == 0) ? 8'h6D : 8'h7D;
      bus1.seg_stb = 1'b1;
    end
    @(negedge hz100);
    bus1.seg_stb = 1'b0;
    capture(1'b0);
    check_output("b2b_vv", got_vv, 1);
    check_output("b2b_value", got_value, 56);

    // Reset between tens and ones clears outputs at once and drops the tens frame.
    apply_stimulus(1'b0, 1'b1, 8'h07);
    #2 reset = 1'b1;
    #1 capture(1'b0);
    check_output("mid_rst_value", got_value, 0);
    check_output("mid_rst_vv",    got_vv,    0);
    check_output("mid_rst_err",   got_err,   0);
    check_output("mid_rst_cnt",   got_cnt,   0);
    @(negedge hz100);
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'h3F);
    check_output("post_rst_err", got_err, 1);
    check_output("post_rst_cnt", got_cnt, 1);

    // STABLE=1 instance: immediate publish, no re-pulse on repeat.
    apply_pair(1'b1, 8'h4F, 8'h07);
    check_output("s1_vv", got_vv, 1);
    check_output("s1_value", got_value, 37);
    apply_pair(1'b1, 8'h4F, 8'h07);
    check_output("s1_rep_vv", got_vv, 0);

    // ERR_W=2 instance: five illegal pairs saturate the count at 3.
    for (int i = 0; i < 5; i++) begin
      apply_pair(1'b1, 8'h00, 8'h00);
      check_output("sat_err", got_err, 1);
      check_output("sat_cnt", got_cnt, (i < 3) ? 32'(i + 1) : 32'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_readback_decoder.md
# seg_readback_decoder

Sequential readback decoder for the two-digit seven-segment interface: it samples the tens and ones segment patterns off a time-multiplexed segment bus, converts them back to a binary value in the range 0–99, and publishes that value only after it has been stable for a configurable number of frame pairs. It sits on the display side of the clock datapath as a self-check and loopback monitor, and flags any pattern the two-digit display encoder cannot legally produce.

## Interface
Parameters:
- STABLE, default 3: number of consecutive identical, legal frame pairs required before `value` updates. Legal range is 1–15.
- ERR_W, default 8: width of the saturating error counter.

Ports:
- hz100  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  8  segment pattern; bit0 = a … bit6 = g, bit7 = decimal point.
- seg_sel  input  1  digit select qualifying `seg_in`: 1 = tens (left digit), 0 = ones (right digit).
- seg_stb  input  1  one-cycle strobe; `seg_in` and `seg_sel` are valid only when this is high.
- value  output  7  last published value, 0–99.
- value_valid  output  1  one-cycle pulse when `value` is (re)published.
- err  output  1  one-cycle pulse on an illegal pattern or sequencing error.
- err_count  output  ERR_W  saturating count of `err` pulses.

## Operation
- Pattern decode, after the bit7 policy in Configuration is applied:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - Every other pattern is illegal, including blank 0x00 (the encoder's output for tens ≥ 10).
- FSM states:
  - WAIT_TENS:
    - Strobe with sel=1: latch `seg_in` as the tens pattern, go to WAIT_ONES.
    - Strobe with sel=0: sequencing error. Pulse `err`, stay in WAIT_TENS, leave the match count unchanged.
  - WAIT_ONES:
    - Strobe with sel=1: overwrite the latched tens pattern, no error, stay in WAIT_ONES.
    - Strobe with sel=0: evaluate the pair (below), go to WAIT_TENS.
- Pair evaluation:
  - If either digit is illegal: pulse `err`, clear the match count to 0, clear the candidate-valid flag.
  - Otherwise compute candidate = tens×10 + ones as 7 bits (maximum 99, no overflow).
    - If candidate-valid is set and candidate equals the held candidate: match count increments, saturating at STABLE.
    - Else: hold the new candidate, set candidate-valid, match count = 1.
  - Publish when the match count transitions to STABLE in this evaluation:
    - `value` ← candidate, `value_valid` pulses.
    - Further matching pairs while already saturated do not re-pulse.
  - With STABLE=1, every legal pair whose candidate differs from the held one publishes. A legal pair that repeats a held, already-published candidate does not re-pulse.
- `err_count` increments on every `err` pulse and saturates at all-ones.
- `err` and `value_valid` can never assert in the same cycle.

## Timing
- All outputs are registered.
- `value`, `value_valid` and `err` respond in the cycle after the `seg_stb` cycle that caused them (latency 1).
- `err_count` reflects the increment in the same cycle that `err` is high.
- Strobes may arrive on back-to-back cycles; each one is processed, and none is dropped.
- While `seg_stb` is low, `seg_in` and `seg_sel` are ignored.
- Reset values:
  - `value` = 0, `value_valid` = 0, `err` = 0, `err_count` = 0.
  - State = WAIT_TENS, match count = 0, candidate-valid = 0, held candidate = 0, latched tens = 0.
- Reset asserted mid-pair discards the latched tens pattern. The first strobe after release must be a tens frame.

## Configuration
- SEG_DP_CHECK_EN:
  - Defined: any pattern with bit7 = 1 is illegal and raises `err` through the normal illegal-pair path.
  - Undefined: bit7 is masked to 0 before decode, so a lit decimal point is ignored.

## Test plan
- Reset, then pairs (0x4F tens, 0x07 ones) ×3 with STABLE=3 → `value_valid` pulses once, one cycle after the 3rd ones strobe, with `value` = 37; a 4th identical pair gives no pulse.
- Pairs 37, 37, 42, 42, 42 → no publish at 37; publish 42 after the 5th pair; `err` never asserts.
- Tens 0x00, ones 0x3F (encoder output for 100) → `err` pulse, `err_count` = 1, match count cleared; subsequent 3× (0x06, 0x3F) → `value` = 10.
- Ones strobe received in WAIT_TENS → `err` pulse, state stays WAIT_TENS. Tens 0x5B then tens 0x66 then ones 0x6F → pair evaluated as 49.
- Tens 0xBF (0x3F plus decimal point) with ones 0x3F ×3 → without SEG_DP_CHECK_EN publishes `value` = 0 after the 3rd pair; with it, `err` pulses three times and `err_count` = 3.
- ERR_W=2, five consecutive illegal pairs → `err_count` saturates at 3. Reset asserted between a tens and a ones strobe → all outputs return to their reset values immediately.
